// File: rtl/if_id_decode_pkg.sv
// ---------------------------------------------------------------------------
// if_id_decode_pkg
// Shared types for the IF/ID -> ID/EX decode slice: opcode encoding, the
// "no instruction" marker word, pipeline register layouts, the halt-drain
// state type and the immediate sign-extension helper.
// ---------------------------------------------------------------------------
package if_id_decode_pkg;

  localparam int add_width   = 32;
  localparam int instr_width = 32;

  localparam logic [31:0] NOP_WORD = 32'hDEADBEEF;

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000,
    OP_ADDI = 6'b000001,
    OP_SUB  = 6'b000010,
    OP_SUBI = 6'b000011,
    OP_MUL  = 6'b000100,
    OP_MULI = 6'b000101,
    OP_OR   = 6'b000110,
    OP_ORI  = 6'b000111,
    OP_AND  = 6'b001000,
    OP_ANDI = 6'b001001,
    OP_XOR  = 6'b001010,
    OP_XORI = 6'b001011,
    OP_LDW  = 6'b001100,
    OP_STW  = 6'b001101,
    OP_BZ   = 6'b001110,
    OP_BEQ  = 6'b001111,
    OP_JR   = 6'b010000,
    OP_HALT = 6'b010001
  } opcode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  // IF/ID payload; its valid bit travels beside it as a separate flop.
  typedef struct packed {
    logic [instr_width-1:0] instr;
    logic [add_width-1:0]   pc4;
  } IfId_t;

  // ID/EX payload; its valid bit travels beside it as a separate flop.
  typedef struct packed {
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           dest;
    logic [31:0]          imm;
    logic [add_width-1:0] pc4;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 is_branch;
  } IdEx_t;

  function automatic logic signed [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/if_id_decode_if.sv
// ---------------------------------------------------------------------------
// if_id_decode_if
// Fetch <-> decode link. Fetch (master) presents the fetched word and its
// PC+4; decode (slave) answers with the stall and halt-freeze requests.
//   instruction     : fetched word, 32'hDEADBEEF when nothing was fetched
//   pc_added4       : PC+4 of that word
//   hazard_detected : load-use stall, fetch holds its PC
//   halt_detected   : HALT seen or pipeline draining, fetch freezes its PC
// ---------------------------------------------------------------------------
interface if_id_decode_if #(
  parameter int ADD_WIDTH   = 32,
  parameter int INSTR_WIDTH = 32
);

  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADD_WIDTH-1:0]   pc_added4;
  logic                   hazard_detected;
  logic                   halt_detected;

  modport master (
    output instruction,
    output pc_added4,
    input  hazard_detected,
    input  halt_detected
  );

  modport slave (
    input  instruction,
    input  pc_added4,
    output hazard_detected,
    output halt_detected
  );

endinterface

// File: rtl/if_id_decode_instr_decoder.sv
// ---------------------------------------------------------------------------
// if_id_decode_instr_decoder
// Purely combinational decode of one instruction word.
//   word      : instruction word
//   dest      : destination register (0 when the op writes nothing)
//   uses_rs   : op reads the rs field
//   uses_rt   : op reads the rt field
//   reg_write, mem_read, mem_write, is_branch : control bits
//   imm       : word[15:0] sign-extended
//   legal     : opcode is one of the defined opcodes
// ---------------------------------------------------------------------------
module if_id_decode_instr_decoder
  import if_id_decode_pkg::*;
(
  input  logic [instr_width-1:0] word,
  output logic [4:0]             dest,
  output logic                   uses_rs,
  output logic                   uses_rt,
  output logic                   reg_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   is_branch,
  output logic signed [31:0]     imm,
  output logic                   legal
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op  = word[31:26];
  assign rt  = word[20:16];
  assign rd  = word[15:11];
  assign imm = sign_ext16(word[15:0]);

  always_comb begin
    dest      = 5'd0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    is_branch = 1'b0;
    legal     = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        dest      = rd;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        reg_write = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        dest      = rt;
        uses_rs   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LDW: begin
        dest      = rt;
        uses_rs   = 1'b1;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OP_STW: begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BZ, OP_JR: begin
        uses_rs   = 1'b1;
        is_branch = 1'b1;
      end
      OP_BEQ: begin
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        is_branch = 1'b1;
      end
      OP_HALT: begin
      end
      // Unknown opcodes read nothing so they can never raise a stall.
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_decode.sv
// ---------------------------------------------------------------------------
// if_id_decode
// Consumer end of instruction fetch: IF/ID register, decode into the ID/EX
// register, load-use stall detection, branch flush and a halt-drain FSM.
//   clock, rst     : rising-edge clock, synchronous active-low reset
//   fetch          : fetch link (instruction, pc_added4 in;
//                    hazard_detected, halt_detected out)
//   is_taken       : branch/jump resolved taken in EX, squashes IF/ID
//   id_rs, id_rt   : register-file read addresses from IF/ID
//   idex_*         : ID/EX register contents
//   illegal_op     : one-cycle pulse when an unknown opcode is decoded
//   pipeline_done  : sticky once the post-HALT drain has completed
// ---------------------------------------------------------------------------
module if_id_decode
  import if_id_decode_pkg::*;
#(
  parameter int ADD_WIDTH    = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 rst,
  if_id_decode_if.slave        fetch,
  input  logic                 is_taken,
  output logic [4:0]           id_rs,
  output logic [4:0]           id_rt,
  output logic                 idex_valid,
  output logic [5:0]           idex_opcode,
  output logic [4:0]           idex_rs,
  output logic [4:0]           idex_rt,
  output logic [4:0]           idex_dest,
  output logic [31:0]          idex_imm,
  output logic [ADD_WIDTH-1:0] idex_pc4,
  output logic                 idex_reg_write,
  output logic                 idex_mem_read,
  output logic                 idex_mem_write,
  output logic                 idex_is_branch,
  output logic                 illegal_op,
  output logic                 pipeline_done
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_WORD);

  IfId_t       ifid_p0;
  logic        vld_p0;
  IdEx_t       idex_p1;
  IdEx_t       idex_nxt;
  logic        vld_p1;

  halt_state_t state;
  halt_state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [4:0]        dec_dest;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_is_branch;
  logic signed [31:0] dec_imm;
  logic              dec_legal;

  logic [5:0] op_p0;
  logic [4:0] rs_p0;
  logic [4:0] rt_p0;
  logic       running;
  logic       halt_in_id;
  logic       halt_take;
  logic       hazard;
  logic       load_idex;

  if_id_decode_instr_decoder u_instr_decoder (
    .word      (ifid_p0.instr),
    .dest      (dec_dest),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .is_branch (dec_is_branch),
    .imm       (dec_imm),
    .legal     (dec_legal)
  );

  assign op_p0      = ifid_p0.instr[31:26];
  assign rs_p0      = ifid_p0.instr[25:21];
  assign rt_p0      = ifid_p0.instr[20:16];
  assign running    = (state == RUN);
  assign halt_in_id = vld_p0 && (op_p0 == OP_HALT);
  assign halt_take  = halt_in_id && !is_taken;

  // A load in EX whose destination is read by the instruction in ID. A taken
  // branch kills the ID instruction anyway, so it never needs to stall.
  assign hazard = running && !is_taken && vld_p1 && idex_p1.mem_read &&
                  (idex_p1.dest != 5'd0) && vld_p0 &&
                  ((dec_uses_rs && (idex_p1.dest == rs_p0)) ||
                   (dec_uses_rt && (idex_p1.dest == rt_p0)));

  assign load_idex = running && vld_p0 && dec_legal && !halt_in_id &&
                     !hazard && !is_taken;

  assign fetch.hazard_detected = hazard;
  assign fetch.halt_detected   = halt_take || !running;

  // ---- IF -> IF/ID (stage p0) ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      ifid_p0 <= '0;
    end else if (running) begin
      if (is_taken) begin
        vld_p0 <= 1'b0;
      end else if (!hazard) begin
        vld_p0        <= (fetch.instruction != NOP);
        ifid_p0.instr <= fetch.instruction;
        ifid_p0.pc4   <= fetch.pc_added4;
      end
    end
  end

  always_comb begin
    idex_nxt = '0;
    if (load_idex) begin
      idex_nxt.opcode    = op_p0;
      idex_nxt.rs        = rs_p0;
      idex_nxt.rt        = rt_p0;
      idex_nxt.dest      = dec_dest;
      idex_nxt.imm       = dec_imm;
      idex_nxt.pc4       = ifid_p0.pc4;
      idex_nxt.reg_write = dec_reg_write;
      idex_nxt.mem_read  = dec_mem_read;
      idex_nxt.mem_write = dec_mem_write;
      idex_nxt.is_branch = dec_is_branch;
    end
  end

  // ---- ID -> ID/EX (stage p1) ----
  always_ff @(posedge clock) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      idex_p1    <= '0;
      illegal_op <= 1'b0;
    end else begin
      vld_p1     <= load_idex;
      idex_p1    <= idex_nxt;
      illegal_op <= running && !is_taken && vld_p0 && !dec_legal;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter covers the EX, MEM and WB slots still occupied when HALT
  // leaves ID; HALTED is reached DRAIN_CYCLES edges after entering DRAIN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (halt_take) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nxt = HALTED;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALTED: begin
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pipeline_done = (state == HALTED);

  assign id_rs          = rs_p0;
  assign id_rt          = rt_p0;
  assign idex_valid     = vld_p1;
  assign idex_opcode    = idex_p1.opcode;
  assign idex_rs        = idex_p1.rs;
  assign idex_rt        = idex_p1.rt;
  assign idex_dest      = idex_p1.dest;
  assign idex_imm       = idex_p1.imm;
  assign idex_pc4       = idex_p1.pc4;
  assign idex_reg_write = idex_p1.reg_write;
  assign idex_mem_read  = idex_p1.mem_read;
  assign idex_mem_write = idex_p1.mem_write;
  assign idex_is_branch = idex_p1.is_branch;

endmodule

// File: tb/tb_if_id_decode.sv
// ---------------------------------------------------------------------------
// tb_if_id_decode
// Directed scenarios with literal expectations followed by a randomized run.
// A behavioural model of the decode stage is compared against the DUT on
// every falling clock edge once the first reset has been applied.
// ---------------------------------------------------------------------------
module tb_if_id_decode;
  import if_id_decode_pkg::*;

  localparam int DRAIN = 3;

  logic        clock;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc_added4;
  logic        is_taken;

  logic [4:0]  id_rs, id_rt;
  logic        idex_valid;
  logic [5:0]  idex_opcode;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic [31:0] idex_imm, idex_pc4;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_is_branch;
  logic        illegal_op, pipeline_done;

  int n_chk;
  int n_fail;
  logic [31:0] pc_next;

  if_id_decode_if #(.ADD_WIDTH(32), .INSTR_WIDTH(32)) fetch_bus ();
  assign fetch_bus.instruction = instruction;
  assign fetch_bus.pc_added4   = pc_added4;

  if_id_decode #(.ADD_WIDTH(32), .INSTR_WIDTH(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clock          (clock),
    .rst            (rst),
    .fetch          (fetch_bus),
    .is_taken       (is_taken),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .idex_valid     (idex_valid),
    .idex_opcode    (idex_opcode),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .idex_dest      (idex_dest),
    .idex_imm       (idex_imm),
    .idex_pc4       (idex_pc4),
    .idex_reg_write (idex_reg_write),
    .idex_mem_read  (idex_mem_read),
    .idex_mem_write (idex_mem_write),
    .idex_is_branch (idex_is_branch),
    .illegal_op     (illegal_op),
    .pipeline_done  (pipeline_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          armed;
  bit          m_if_v;
  logic [31:0] m_if_w, m_if_pc;
  bit          m_ex_v;
  logic [5:0]  m_ex_op;
  logic [4:0]  m_ex_rs, m_ex_rt, m_ex_dest;
  logic [31:0] m_ex_imm, m_ex_pc;
  bit          m_ex_rw, m_ex_mr, m_ex_mw, m_ex_br;
  bit          m_ill;
  int          m_since;   // edges since HALT was accepted; 0 while running

  // Opcodes 0..11 alternate register form (even) / immediate form (odd).
  function automatic void mdec(input logic [31:0] w, output bit legal, output bit urs,
                               output bit urt, output logic [4:0] dest, output bit rw,
                               output bit mr, output bit mw, output bit br);
    int op;
    bit reg_form;
    op       = int'(w[31:26]);
    reg_form = (op <= 11) && (op % 2 == 0);
    legal    = (op <= 17);
    rw       = (op <= 12);
    mr       = (op == 12);
    mw       = (op == 13);
    br       = (op >= 14) && (op <= 16);
    urs      = (op <= 16);
    urt      = reg_form || (op == 13) || (op == 15);
    if (reg_form)      dest = w[15:11];
    else if (op <= 12) dest = w[20:16];
    else               dest = 5'd0;
  endfunction

  function automatic bit m_hazard();
    bit legal, urs, urt, rw, mr, mw, br;
    logic [4:0] dest;
    mdec(m_if_w, legal, urs, urt, dest, rw, mr, mw, br);
    return (m_since == 0) && !is_taken && m_ex_v && m_ex_mr && (m_ex_dest != 0) && m_if_v &&
           ((urs && m_ex_dest == m_if_w[25:21]) || (urt && m_ex_dest == m_if_w[20:16]));
  endfunction

  function automatic bit m_halt_in_id();
    return m_if_v && (m_if_w[31:26] == 6'd17);
  endfunction

  always @(posedge clock) begin
    bit legal, urs, urt, rw, mr, mw, br, h, run;
    logic [4:0] dest;
    if (!rst) begin
      armed = 1'b1;
      m_if_v = 0; m_if_w = 0; m_if_pc = 0;
      m_ex_v = 0; m_ex_op = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_dest = 0;
      m_ex_imm = 0; m_ex_pc = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_mw = 0; m_ex_br = 0;
      m_ill = 0; m_since = 0;
    end else if (armed) begin
      mdec(m_if_w, legal, urs, urt, dest, rw, mr, mw, br);
      h   = m_hazard();
      run = (m_since == 0);
      m_ill = run && !is_taken && m_if_v && !legal;
      if (run && m_if_v && legal && !m_halt_in_id() && !h && !is_taken) begin
        m_ex_v = 1; m_ex_op = m_if_w[31:26]; m_ex_rs = m_if_w[25:21]; m_ex_rt = m_if_w[20:16];
        m_ex_dest = dest; m_ex_imm = 32'(int'($signed(m_if_w[15:0]))); m_ex_pc = m_if_pc;
        m_ex_rw = rw; m_ex_mr = mr; m_ex_mw = mw; m_ex_br = br;
      end else begin
        m_ex_v = 0; m_ex_op = 0; m_ex_rs = 0; m_ex_rt = 0; m_ex_dest = 0;
        m_ex_imm = 0; m_ex_pc = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_mw = 0; m_ex_br = 0;
      end
      if (m_since > 0) begin
        if (m_since < 100) m_since++;
      end else if (m_halt_in_id() && !is_taken) begin
        m_since = 1;
      end
      if (run) begin
        if (is_taken) m_if_v = 0;
        else if (!h) begin
          m_if_v = (instruction != NOP_WORD); m_if_w = instruction; m_if_pc = pc_added4;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("hazard_detected", fetch_bus.hazard_detected, m_hazard());
      chk("halt_detected", fetch_bus.halt_detected,
          (m_halt_in_id() && !is_taken) || (m_since != 0));
      if (m_if_v) begin
        chk("id_rs", id_rs, m_if_w[25:21]);
        chk("id_rt", id_rt, m_if_w[20:16]);
      end
      chk("idex_valid", idex_valid, m_ex_v);
      chk("idex_opcode", idex_opcode, m_ex_op);
      chk("idex_rs", idex_rs, m_ex_rs);
      chk("idex_rt", idex_rt, m_ex_rt);
      chk("idex_dest", idex_dest, m_ex_dest);
      chk("idex_imm", idex_imm, m_ex_imm);
      chk("idex_pc4", idex_pc4, m_ex_pc);
      chk("idex_ctrl", {idex_reg_write, idex_mem_read, idex_mem_write, idex_is_branch},
          {m_ex_rw, m_ex_mr, m_ex_mw, m_ex_br});
      chk("illegal_op", illegal_op, m_ill);
      chk("pipeline_done", pipeline_done, m_since >= DRAIN + 1);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Inputs change 2 time units after the rising edge; returns 1 unit later
  // so the caller observes the state left by that edge.
  task automatic drive(input logic [31:0] w, input logic t, input logic r);
    @(posedge clock);
    #2;
    instruction = w;
    pc_added4   = pc_next;
    pc_next     = pc_next + 32'd4;
    is_taken    = t;
    rst         = r;
    #1;
  endtask

  initial begin
    logic [31:0] w;
    int op;
    n_chk = 0; n_fail = 0; armed = 1'b0;
    pc_next = 32'h0000_1000;
    rst = 1'b0; instruction = NOP_WORD; pc_added4 = 32'd0; is_taken = 1'b0;

    drive(NOP_WORD, 0, 0);
    drive(NOP_WORD, 0, 1);
    chk("reset idex_valid", idex_valid, 0);
    chk("reset idex_pc4", idex_pc4, 0);
    chk("reset pipeline_done", pipeline_done, 0);
    chk("reset halt_detected", fetch_bus.halt_detected, 0);
    chk("reset illegal_op", illegal_op, 0);

    // Load-use: LDW r2,0(r1) then ADD r3,r2,r4
    drive(enc_i(12, 1, 2, 0), 0, 1);
    drive(enc_r(0, 2, 4, 3), 0, 1);
    drive(NOP_WORD, 0, 1);
    chk("loaduse hazard on", fetch_bus.hazard_detected, 1);
    chk("loaduse ldw in ex", {idex_valid, idex_mem_read, idex_dest}, {1'b1, 1'b1, 5'd2});
    drive(NOP_WORD, 0, 1);
    chk("loaduse hazard off", fetch_bus.hazard_detected, 0);
    chk("loaduse bubble", idex_valid, 0);
    chk("loaduse add held rs", id_rs, 2);
    drive(NOP_WORD, 0, 1);
    chk("loaduse add in ex", {idex_valid, idex_dest, idex_opcode}, {1'b1, 5'd3, 6'd0});

    // Load to r0 never stalls
    drive(enc_i(12, 1, 0, 0), 0, 1);
    drive(enc_r(0, 0, 4, 3), 0, 1);
    drive(NOP_WORD, 0, 1);
    chk("r0 load no hazard", fetch_bus.hazard_detected, 0);

    // Branch flush of SUB in IF/ID
    drive(enc_r(2, 5, 6, 7), 0, 1);
    drive(NOP_WORD, 1, 1);
    drive(NOP_WORD, 0, 1);
    chk("flush sub bubble", idex_valid, 0);

    // Flush together with a load-use hazard
    drive(enc_i(12, 1, 2, 0), 0, 1);
    drive(enc_r(0, 2, 4, 3), 0, 1);
    drive(NOP_WORD, 1, 1);
    chk("flush beats hazard", fetch_bus.hazard_detected, 0);
    drive(NOP_WORD, 0, 1);
    chk("flush beats hazard bubble", idex_valid, 0);

    // Squashed HALT, then ADDI r7,r1,-5 decodes normally
    drive(enc_i(17, 0, 0, 0), 0, 1);
    drive(NOP_WORD, 1, 1);
    chk("squashed halt_detected", fetch_bus.halt_detected, 0);
    drive(enc_i(1, 1, 7, -5), 0, 1);
    drive(NOP_WORD, 0, 1);
    drive(NOP_WORD, 0, 1);
    chk("post-squash addi", {idex_valid, idex_dest, idex_reg_write}, {1'b1, 5'd7, 1'b1});
    chk("post-squash imm", idex_imm, 32'hFFFF_FFFB);

    // Halt drain
    drive(enc_i(17, 0, 0, 0), 0, 1);
    drive(NOP_WORD, 0, 1);
    chk("halt_detected in id", fetch_bus.halt_detected, 1);
    for (int i = 1; i <= DRAIN + 1; i++) begin
      drive(enc_r(0, 1, 2, 3), 0, 1);
      chk("drain bubble", idex_valid, 0);
      chk("pipeline_done timing", pipeline_done, (i == DRAIN + 1));
    end

    // Reset mid-drain, then illegal opcode
    drive(NOP_WORD, 0, 0);
    drive(enc_i(17, 0, 0, 0), 0, 1);
    drive(NOP_WORD, 0, 1);
    drive(NOP_WORD, 0, 1);
    drive(NOP_WORD, 0, 0);
    drive(NOP_WORD, 0, 1);
    chk("midreset done", pipeline_done, 0);
    chk("midreset halt", fetch_bus.halt_detected, 0);
    chk("midreset id_rs", id_rs, 0);
    drive(32'hFC00_0000, 0, 1);
    drive(NOP_WORD, 0, 1);
    drive(NOP_WORD, 0, 1);
    chk("illegal pulse", {illegal_op, idex_valid}, {1'b1, 1'b0});
    drive(NOP_WORD, 0, 1);
    chk("illegal pulse end", illegal_op, 0);

    // Randomized run
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        w = NOP_WORD;
      end else begin
        op = $urandom_range(0, 18);
        if (op == 18) op = 63;
        if (op == 17 && $urandom_range(0, 3) != 0) op = 12;
        w = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 11'($urandom)};
      end
      drive(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) != 0));
    end
    drive(NOP_WORD, 0, 1);
    @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_decode.md
Name: if_id_decode

Overview:
- Consumer end of the instruction-fetch interface: captures the fetched word and pc_added4 into the IF/ID register, then decodes them into the ID/EX register.
- Drives the fetch-side controls hazard_detected and halt_detected.
- Applies the branch flush from EX (is_taken).
- Runs a halt-drain FSM so the pipeline empties cleanly after HALT.

Parameters:
- ADD_WIDTH, 32, PC/address width (matches package add_width).
- INSTR_WIDTH, 32, instruction width (matches package instr_width).
- DRAIN_CYCLES, 3, cycles after HALT leaves ID before pipeline_done (EX, MEM, WB).

Ports:
- clock in 1: system clock, all state on rising edge.
- rst in 1: reset, synchronous, active-low.
- instruction in INSTR_WIDTH: word from fetch; 32'hDEADBEEF marks no valid instruction.
- pc_added4 in ADD_WIDTH: fetch PC+4.
- is_taken in 1: branch/jump resolved taken in EX.
- hazard_detected out 1: load-use stall; fetch holds PC.
- halt_detected out 1: fetch freezes PC.
- id_rs out 5: regfile read address A, instr[25:21] of IF/ID.
- id_rt out 5: regfile read address B, instr[20:16] of IF/ID.
- idex_valid out 1: ID/EX holds a real instruction.
- idex_opcode out 6: opcode of the ID/EX instruction.
- idex_rs out 5: rs field of the ID/EX instruction.
- idex_rt out 5: rt field of the ID/EX instruction.
- idex_dest out 5: destination register; 0 if none.
- idex_imm out 32: instr[15:0] sign-extended.
- idex_pc4 out ADD_WIDTH: PC+4 of the ID/EX instruction.
- idex_reg_write out 1: control bit.
- idex_mem_read out 1: control bit.
- idex_mem_write out 1: control bit.
- idex_is_branch out 1: control bit.
- illegal_op out 1: pulses one cycle when an unknown opcode is decoded.
- pipeline_done out 1: sticky once the drain completes.

Behaviour:
- Reset (rst==0 at a clock edge):
  - Both pipeline registers become invalid; all idex_* are 0.
  - FSM goes to RUN; illegal_op and pipeline_done are 0.
  - Reset has priority over every other event, including mid-drain.
- IF/ID capture:
  - On each edge, if not stalled, IF/ID.valid = (instruction != DEADBEEF) and the word and pc_added4 are captured.
  - Stalled (hazard_detected): IF/ID holds.
  - is_taken: IF/ID.valid goes to 0 (wrong-path squash). is_taken beats stall.
- Decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Destination register:
  - R-type (ADD/SUB/MUL/OR/AND/XOR): rd.
  - I-type ALU and LDW: rt.
  - STW, BZ, BEQ, JR, HALT: reg_write=0, dest=0.
- Register usage:
  - uses_rs: every opcode except HALT.
  - uses_rt: R-type, STW, BEQ.
- Load-use hazard (combinational):
  - Fires when idex_valid and idex_mem_read and idex_dest!=0 and IF/ID.valid.
  - And (uses_rs and idex_dest==rs) or (uses_rt and idex_dest==rt).
  - hazard_detected is forced to 0 when is_taken or state!=RUN.
- ID/EX update:
  - Loaded with the decoded IF/ID instruction when IF/ID.valid and the opcode is legal.
  - Becomes a bubble (valid=0, all controls 0) on hazard, is_taken, illegal opcode, HALT, or state!=RUN.
- halt_detected = (IF/ID.valid and opcode==HALT and !is_taken) or state!=RUN.
- FSM:
  - RUN: HALT in ID and !is_taken → DRAIN, counter=DRAIN_CYCLES-1. A HALT squashed by is_taken stays in RUN.
  - DRAIN: counter decrements each cycle; when counter==0 → HALTED.
  - HALTED: terminal until reset.
  - pipeline_done = (state==HALTED).
- While DRAIN/HALTED: IF/ID is held and ID/EX stays a bubble.
- Zero latency: instruction/pc_added4 → IF/ID is 1 edge; IF/ID → ID/EX is 1 edge.

Decomposition:
- Package Types (shared, extended):
  - opcode enum: ADD=000000, ADDI=000001, SUB=000010, SUBI=000011, MUL=000100, MULI=000101, OR=000110, ORI=000111, AND=001000, ANDI=001001, XOR=001010, XORI=001011, LDW=001100, STW=001101, BZ=001110, BEQ=001111, JR=010000, HALT=010001.
  - NOP_WORD constant = 32'hDEADBEEF.
  - IfId_t struct and IdEx_t struct.
  - halt_state_t enum {RUN, DRAIN, HALTED}.
- One sub-module: instr_decoder, purely combinational. It maps a word to dest, uses_rs, uses_rt, the controls, imm and legal.

Test Plan:
- Load-use stall: LDW r2,0(r1) then ADD r3,r2,r4:
  - hazard_detected=1 for exactly 1 cycle.
  - IF/ID holds ADD; ID/EX shows a bubble, then ADD with dest=3.
- Load to r0: LDW r0 then ADD r3,r0,r4 → hazard_detected stays 0.
- Branch flush: is_taken=1 while IF/ID holds SUB → next cycle idex_valid=0 and IF/ID.valid=0. is_taken together with a load-use hazard → hazard_detected=0 and the flush wins.
- Halt drain: HALT reaches ID →
  - halt_detected=1 the same cycle.
  - idex_valid=0 for the following cycles.
  - pipeline_done=1 exactly 4 edges after HALT was in ID (1 to enter DRAIN + DRAIN_CYCLES=3).
- Squashed halt: HALT in ID with is_taken=1 → halt_detected=0, state stays RUN, and the next fetched instruction decodes normally.
- Reset mid-drain: rst=0 during DRAIN for 1 edge → state RUN and all outputs 0. An instruction with opcode 111111 after that → illegal_op pulses 1 cycle and idex_valid=0.
